// File: rtl/idu_issue_ctrl.sv
// Issue stage: holds one decoded instruction (slot A), checks it against the register
// scoreboard, and issues through a registered output slot (slot B). Optional macro: ISSUE_PERF_CNT_EN.
//
// slot A state | meaning
// S_EMPTY      | no instruction held
// S_HAZARD     | held instruction has a pending source register
// S_BLOCKED    | hazard-free but slot B is full and EXU is not accepting
// S_GO         | instruction moves into slot B this cycle
module idu_issue_ctrl #(
  parameter int N_REG     = 32,
  parameter int PAYLOAD_W = 64,
  localparam int AW       = $clog2(N_REG)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 pipe_flush,
  input  logic                 dec_valid,
  output logic                 dec_ready,
  input  logic [AW-1:0]        dec_rs1_addr,
  input  logic [AW-1:0]        dec_rs2_addr,
  input  logic                 dec_rs1_en,
  input  logic                 dec_rs2_en,
  input  logic [AW-1:0]        dec_rd_addr,
  input  logic                 dec_rd_en,
  input  logic [PAYLOAD_W-1:0] dec_payload,
  output logic [AW-1:0]        rs1_addr,
  output logic [AW-1:0]        rs2_addr,
  output logic                 rs1_rd_en,
  output logic                 rs2_rd_en,
  input  logic                 rs1_hit,
  input  logic                 rs2_hit,
  output logic [AW-1:0]        set_rd_addr,
  output logic                 set_rd_wr_en,
  output logic                 iss_valid,
  input  logic                 iss_ready,
  output logic [AW-1:0]        iss_rd_addr,
  output logic                 iss_rd_en,
  output logic [PAYLOAD_W-1:0] iss_payload
`ifdef ISSUE_PERF_CNT_EN
  ,
  output logic [31:0]          perf_haz_stall_cnt,
  output logic [31:0]          perf_blk_stall_cnt
`endif
);

  typedef enum logic [1:0] {S_EMPTY, S_HAZARD, S_BLOCKED, S_GO} a_state_e;

  a_state_e a_state;
  logic     hazard;
  logic     move;

  logic                 a_valid_q, a_valid_d;
  logic [AW-1:0]        a_rs1_q, a_rs1_d;
  logic [AW-1:0]        a_rs2_q, a_rs2_d;
  logic                 a_rs1_en_q, a_rs1_en_d;
  logic                 a_rs2_en_q, a_rs2_en_d;
  logic [AW-1:0]        a_rd_q, a_rd_d;
  logic                 a_rd_en_q, a_rd_en_d;
  logic [PAYLOAD_W-1:0] a_pay_q, a_pay_d;
  logic                 b_valid_q, b_valid_d;
  logic [AW-1:0]        b_rd_q, b_rd_d;
  logic                 b_rd_en_q, b_rd_en_d;
  logic [PAYLOAD_W-1:0] b_pay_q, b_pay_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_valid_q  <= 1'b0;
      a_rs1_q    <= '0;
      a_rs2_q    <= '0;
      a_rs1_en_q <= 1'b0;
      a_rs2_en_q <= 1'b0;
      a_rd_q     <= '0;
      a_rd_en_q  <= 1'b0;
      a_pay_q    <= '0;
      b_valid_q  <= 1'b0;
      b_rd_q     <= '0;
      b_rd_en_q  <= 1'b0;
      b_pay_q    <= '0;
    end else begin
      a_valid_q  <= a_valid_d;
      a_rs1_q    <= a_rs1_d;
      a_rs2_q    <= a_rs2_d;
      a_rs1_en_q <= a_rs1_en_d;
      a_rs2_en_q <= a_rs2_en_d;
      a_rd_q     <= a_rd_d;
      a_rd_en_q  <= a_rd_en_d;
      a_pay_q    <= a_pay_d;
      b_valid_q  <= b_valid_d;
      b_rd_q     <= b_rd_d;
      b_rd_en_q  <= b_rd_en_d;
      b_pay_q    <= b_pay_d;
    end
  end

  // Flush wins over both the A->B move and a decode load.
  always_comb begin
    a_valid_d  = a_valid_q;
    a_rs1_d    = a_rs1_q;
    a_rs2_d    = a_rs2_q;
    a_rs1_en_d = a_rs1_en_q;
    a_rs2_en_d = a_rs2_en_q;
    a_rd_d     = a_rd_q;
    a_rd_en_d  = a_rd_en_q;
    a_pay_d    = a_pay_q;
    b_valid_d  = b_valid_q;
    b_rd_d     = b_rd_q;
    b_rd_en_d  = b_rd_en_q;
    b_pay_d    = b_pay_q;
    if (pipe_flush) begin
      a_valid_d = 1'b0;
      b_valid_d = 1'b0;
    end else begin
      if (move) begin
        b_valid_d = 1'b1;
        b_rd_d    = a_rd_q;
        b_rd_en_d = a_rd_en_q;
        b_pay_d   = a_pay_q;
      end else if (iss_ready) begin
        b_valid_d = 1'b0;
      end
      if (dec_valid && dec_ready) begin
        a_valid_d  = 1'b1;
        a_rs1_d    = dec_rs1_addr;
        a_rs2_d    = dec_rs2_addr;
        a_rs1_en_d = dec_rs1_en;
        a_rs2_en_d = dec_rs2_en;
        a_rd_d     = dec_rd_addr;
        a_rd_en_d  = dec_rd_en;
        a_pay_d    = dec_payload;
      end else if (move) begin
        a_valid_d = 1'b0;
      end
    end
  end

  always_comb begin
    hazard = rs1_hit | rs2_hit;
    if (!a_valid_q)                  a_state = S_EMPTY;
    else if (hazard)                 a_state = S_HAZARD;
    else if (b_valid_q && !iss_ready) a_state = S_BLOCKED;
    else                             a_state = S_GO;
    move         = (a_state == S_GO) && !pipe_flush;
    dec_ready    = !pipe_flush && (!a_valid_q || move);
    rs1_addr     = a_rs1_q;
    rs2_addr     = a_rs2_q;
    rs1_rd_en    = a_valid_q & a_rs1_en_q;
    rs2_rd_en    = a_valid_q & a_rs2_en_q;
    // x0 is hard-wired, so it never gets a pending bit.
    set_rd_wr_en = move && a_rd_en_q && (a_rd_q != '0);
    set_rd_addr  = a_rd_q;
    iss_valid    = b_valid_q;
    iss_rd_addr  = b_rd_q;
    iss_rd_en    = b_rd_en_q;
    iss_payload  = b_pay_q;
  end

`ifdef ISSUE_PERF_CNT_EN
  logic [31:0] haz_cnt_q, haz_cnt_d;
  logic [31:0] blk_cnt_q, blk_cnt_d;

  always_comb begin
    haz_cnt_d = haz_cnt_q;
    blk_cnt_d = blk_cnt_q;
    if (a_state == S_HAZARD && haz_cnt_q != 32'hFFFF_FFFF) haz_cnt_d = haz_cnt_q + 32'd1;
    if (a_state == S_BLOCKED && blk_cnt_q != 32'hFFFF_FFFF) blk_cnt_d = blk_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      haz_cnt_q <= '0;
      blk_cnt_q <= '0;
    end else begin
      haz_cnt_q <= haz_cnt_d;
      blk_cnt_q <= blk_cnt_d;
    end
  end

  assign perf_haz_stall_cnt = haz_cnt_q;
  assign perf_blk_stall_cnt = blk_cnt_q;
`endif

endmodule
